// File: rtl/xox_game_controller.sv
// Two-player tic-tac-toe referee: arbitrates alternating blue/red moves, keeps the board,
// detects wins and draws, and forfeits a turn after TIMEOUT_CYCLES idle WAIT_MOVE cycles.
module xox_game_controller #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_req,
  input  logic       p2_req,
  input  logic [1:0] p1_row,
  input  logic [1:0] p1_col,
  input  logic [1:0] p2_row,
  input  logic [1:0] p2_col,
  output logic       p1_ack,
  output logic       p2_ack,
  output logic       p1_rej,
  output logic       p2_rej,
  output logic [8:0] cell_blue,
  output logic [8:0] cell_red,
  output logic       turn,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       timeout,
  output logic [3:0] move_count
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_MOVE, CHECK, GAME_OVER} state_t;

  state_t        state_q, state_d;
  logic [8:0]    blue_q, blue_d;
  logic [8:0]    red_q, red_d;
  logic          turn_q, turn_d;
  logic [1:0]    winner_q, winner_d;
  logic          game_over_q, game_over_d;
  logic [3:0]    mc_q, mc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p1_ack_q, p1_ack_d;
  logic          p2_ack_q, p2_ack_d;
  logic          p1_rej_q, p1_rej_d;
  logic          p2_rej_q, p2_rej_d;
  logic          timeout_q, timeout_d;

  logic          cur_req, oth_req, cur_ok;
  logic [8:0]    cur_mask, mover_vec;
  logic          ack_cur, rej_cur, rej_oth, rej_all;

  // One-hot cell select; an all-zero mask marks an invalid (00) coordinate.
  function automatic logic [8:0] cell_mask(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    idx = ({2'b00, col - 2'd1} * 4'd3) + {2'b00, row - 2'd1};
    if (row == 2'd0 || col == 2'd0) return 9'd0;
    return 9'd1 << idx;
  endfunction

  function automatic logic has_line(input logic [8:0] v);
    return (&v[2:0]) | (&v[5:3]) | (&v[8:6]) |
           (v[0] & v[3] & v[6]) | (v[1] & v[4] & v[7]) | (v[2] & v[5] & v[8]) |
           (v[0] & v[4] & v[8]) | (v[2] & v[4] & v[6]);
  endfunction

  assign cur_req   = turn_q ? p2_req : p1_req;
  assign oth_req   = turn_q ? p1_req : p2_req;
  assign cur_mask  = turn_q ? cell_mask(p2_row, p2_col) : cell_mask(p1_row, p1_col);
  assign cur_ok    = cur_req && (cur_mask != 9'd0) && (((blue_q | red_q) & cur_mask) == 9'd0);
  assign mover_vec = turn_q ? red_q : blue_q;

  always_comb begin
    state_d     = state_q;
    blue_d      = blue_q;
    red_d       = red_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    mc_d        = mc_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    ack_cur     = 1'b0;
    rej_cur     = 1'b0;
    rej_oth     = 1'b0;
    rej_all     = 1'b0;

    // start outranks everything, including a same-cycle request (no ack, no rej)
    if (start) begin
      state_d     = WAIT_MOVE;
      blue_d      = '0;
      red_d       = '0;
      turn_d      = 1'b0;
      winner_d    = 2'b00;
      game_over_d = 1'b0;
      mc_d        = '0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        WAIT_MOVE: begin
          rej_oth = oth_req;
          if (cur_ok) begin
            if (turn_q) red_d = red_q | cur_mask;
            else        blue_d = blue_q | cur_mask;
            ack_cur = 1'b1;
            mc_d    = mc_q + 4'd1;
            state_d = CHECK;
          end else begin
            rej_cur = cur_req;
            if (cnt_q == TO_LAST) begin
              turn_d    = ~turn_q;
              cnt_d     = '0;
              timeout_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        CHECK: begin
          rej_all = 1'b1;
          if (has_line(mover_vec)) begin
            winner_d    = turn_q ? 2'b10 : 2'b01;
            game_over_d = 1'b1;
            state_d     = GAME_OVER;
          end else if (mc_q == 4'd9) begin
            winner_d    = 2'b11;
            game_over_d = 1'b1;
            state_d     = GAME_OVER;
          end else begin
            turn_d  = ~turn_q;
            cnt_d   = '0;
            state_d = WAIT_MOVE;
          end
        end
        GAME_OVER: rej_all = 1'b1;
        default:   state_d = IDLE;
      endcase
    end

    p1_ack_d = ack_cur & ~turn_q;
    p2_ack_d = ack_cur & turn_q;
    p1_rej_d = (rej_all & p1_req) | (turn_q ? rej_oth : rej_cur);
    p2_rej_d = (rej_all & p2_req) | (turn_q ? rej_cur : rej_oth);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      blue_q      <= '0;
      red_q       <= '0;
      turn_q      <= 1'b0;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      mc_q        <= '0;
      cnt_q       <= '0;
      p1_ack_q    <= 1'b0;
      p2_ack_q    <= 1'b0;
      p1_rej_q    <= 1'b0;
      p2_rej_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      blue_q      <= blue_d;
      red_q       <= red_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      mc_q        <= mc_d;
      cnt_q       <= cnt_d;
      p1_ack_q    <= p1_ack_d;
      p2_ack_q    <= p2_ack_d;
      p1_rej_q    <= p1_rej_d;
      p2_rej_q    <= p2_rej_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cell_blue  = blue_q;
  assign cell_red   = red_q;
  assign turn       = turn_q;
  assign winner     = winner_q;
  assign game_over  = game_over_q;
  assign move_count = mc_q;
  assign p1_ack     = p1_ack_q;
  assign p2_ack     = p2_ack_q;
  assign p1_rej     = p1_rej_q;
  assign p2_rej     = p2_rej_q;
  assign timeout    = timeout_q;

  // A cell can only ever be claimed by one player.
  a_no_overlap: assert property (@(posedge clk) disable iff (reset) (blue_q & red_q) == 9'd0);

endmodule

// File: tb/tb_xox_game_controller.sv
// Scoreboarded bench: a board-array model predicts every output after each clock edge.
module tb_xox_game_controller;
  localparam int TO = 8;
  localparam int S_IDLE = 0, S_WAIT = 1, S_CHECK = 2, S_OVER = 3;

  logic clk = 1'b0;
  logic reset, start, p1_req, p2_req;
  logic [1:0] p1_row, p1_col, p2_row, p2_col;
  logic p1_ack, p2_ack, p1_rej, p2_rej, turn, game_over, timeout;
  logic [8:0] cell_blue, cell_red;
  logic [1:0] winner;
  logic [3:0] move_count;

  xox_game_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .p1_req(p1_req), .p2_req(p2_req),
    .p1_row(p1_row), .p1_col(p1_col), .p2_row(p2_row), .p2_col(p2_col),
    .p1_ack(p1_ack), .p2_ack(p2_ack), .p1_rej(p1_rej), .p2_rej(p2_rej),
    .cell_blue(cell_blue), .cell_red(cell_red), .turn(turn), .winner(winner),
    .game_over(game_over), .timeout(timeout), .move_count(move_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic a1, a2, j1, j2;
    logic [8:0] b, r;
    logic t;
    logic [1:0] w;
    logic go, to;
    logic [3:0] mc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // model state: own[row][col] = 0 empty, 1 blue, 2 red
  int own[3][3];
  int m_st, m_mc, m_cnt;
  logic m_turn, m_go, m_a1, m_a2, m_j1, m_j2, m_to;
  logic [1:0] m_win;

  int dr_r[9] = '{1, 1, 1, 2, 2, 2, 3, 3, 3};
  int dr_c[9] = '{1, 2, 3, 2, 1, 3, 2, 1, 3};

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) own[r][c] = 0;
    m_turn = 1'b0; m_mc = 0; m_win = 2'b00; m_go = 1'b0; m_cnt = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_st = S_IDLE;
    m_a1 = 0; m_a2 = 0; m_j1 = 0; m_j2 = 0; m_to = 0;
  endtask

  function automatic logic has_line(input int p);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (own[i][0] == p && own[i][1] == p && own[i][2] == p) hit = 1'b1;
      if (own[0][i] == p && own[1][i] == p && own[2][i] == p) hit = 1'b1;
    end
    if (own[0][0] == p && own[1][1] == p && own[2][2] == p) hit = 1'b1;
    if (own[0][2] == p && own[1][1] == p && own[2][0] == p) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_step(input logic st, input logic r1, input logic [1:0] a1r, a1c,
                            input logic r2, input logic [1:0] a2r, a2c);
    logic creq, oreq;
    int cr, cc, me;
    m_a1 = 0; m_a2 = 0; m_j1 = 0; m_j2 = 0; m_to = 0;
    creq = m_turn ? r2 : r1;
    oreq = m_turn ? r1 : r2;
    cr = m_turn ? int'(a2r) : int'(a1r);
    cc = m_turn ? int'(a2c) : int'(a1c);
    me = m_turn ? 2 : 1;
    if (st) begin
      model_clear();
      m_st = S_WAIT;
    end else if (m_st == S_WAIT) begin
      if (oreq) begin if (m_turn) m_j1 = 1; else m_j2 = 1; end
      if (creq && cr != 0 && cc != 0 && own[cr-1][cc-1] == 0) begin
        own[cr-1][cc-1] = me;
        m_mc++;
        m_st = S_CHECK;
        if (m_turn) m_a2 = 1; else m_a1 = 1;
      end else begin
        if (creq) begin if (m_turn) m_j2 = 1; else m_j1 = 1; end
        if (m_cnt == TO - 1) begin m_turn = !m_turn; m_cnt = 0; m_to = 1; end
        else m_cnt++;
      end
    end else if (m_st == S_CHECK) begin
      m_j1 = r1; m_j2 = r2;
      if (has_line(me)) begin
        m_win = (me == 1) ? 2'b01 : 2'b10; m_go = 1; m_st = S_OVER;
      end else if (m_mc == 9) begin
        m_win = 2'b11; m_go = 1; m_st = S_OVER;
      end else begin
        m_turn = !m_turn; m_cnt = 0; m_st = S_WAIT;
      end
    end else if (m_st == S_OVER) begin
      m_j1 = r1; m_j2 = r2;
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        if (own[r][c] == 1) e.b[c*3 + r] = 1'b1;
        if (own[r][c] == 2) e.r[c*3 + r] = 1'b1;
      end
    e.a1 = m_a1; e.a2 = m_a2; e.j1 = m_j1; e.j2 = m_j2;
    e.t = m_turn; e.w = m_win; e.go = m_go; e.to = m_to; e.mc = 4'(m_mc);
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    check_val("sb_depth", 16'(sb.size()), 16'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val("p1_ack", p1_ack, e.a1);
      check_val("p2_ack", p2_ack, e.a2);
      check_val("p1_rej", p1_rej, e.j1);
      check_val("p2_rej", p2_rej, e.j2);
      check_val("cell_blue", cell_blue, e.b);
      check_val("cell_red", cell_red, e.r);
      check_val("turn", turn, e.t);
      check_val("winner", winner, e.w);
      check_val("game_over", game_over, e.go);
      check_val("timeout", timeout, e.to);
      check_val("move_count", move_count, e.mc);
    end
  endtask

  task automatic cycle(input logic st, input logic r1, input logic [1:0] a1r, a1c,
                       input logic r2, input logic [1:0] a2r, a2c);
    start = st; p1_req = r1; p1_row = a1r; p1_col = a1c;
    p2_req = r2; p2_row = a2r; p2_col = a2c;
    model_step(st, r1, a1r, a1c, r2, a2r, a2c);
    sb.push_back(model_exp());
    @(posedge clk); #1;
    compare_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0);
  endtask
  task automatic go();
    cycle(1, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0);
  endtask
  task automatic mv1(input logic [1:0] r, c);
    cycle(0, 1, r, c, 0, 2'd0, 2'd0);
  endtask
  task automatic mv2(input logic [1:0] r, c);
    cycle(0, 0, 2'd0, 2'd0, 1, r, c);
  endtask

  task automatic check_zero(input string pfx);
    check_val({pfx, "_blue"}, cell_blue, 0);
    check_val({pfx, "_red"}, cell_red, 0);
    check_val({pfx, "_turn"}, turn, 0);
    check_val({pfx, "_winner"}, winner, 0);
    check_val({pfx, "_over"}, game_over, 0);
    check_val({pfx, "_mc"}, move_count, 0);
    check_val({pfx, "_pulses"}, {p1_ack, p2_ack, p1_rej, p2_rej, timeout}, 0);
  endtask

  initial begin
    reset = 1; start = 0; p1_req = 0; p2_req = 0;
    p1_row = 0; p1_col = 0; p2_row = 0; p2_col = 0;
    model_reset();
    #12;
    check_zero("rst");
    @(negedge clk); reset = 0;

    // IDLE ignores requests until start
    cycle(0, 1, 2'd1, 2'd1, 0, 2'd0, 2'd0);

    // blue wins on {0,1,2}
    go();
    mv1(2'd1, 2'd1); idle(1); mv2(2'd1, 2'd2); idle(1);
    mv1(2'd2, 2'd1); idle(1); mv2(2'd2, 2'd2); idle(1);
    mv1(2'd3, 2'd1); idle(1);
    check_val("win_blue_vec", cell_blue, 16'h007);
    check_val("win_red_vec", cell_red, 16'h018);
    check_val("win_winner", winner, 1);
    check_val("win_over", game_over, 1);
    check_val("win_mc", move_count, 5);
    mv2(2'd3, 2'd3);
    check_val("over_rej", p2_rej, 1);

    // occupied cell
    go(); mv1(2'd1, 2'd1); idle(1); mv2(2'd1, 2'd1);
    check_val("occ_rej", p2_rej, 1);
    check_val("occ_red", cell_red, 0);
    check_val("occ_turn", turn, 1);

    // both request on blue's turn, then bad coordinates
    go();
    cycle(0, 1, 2'd1, 2'd1, 1, 2'd2, 2'd2);
    check_val("both_ack1", p1_ack, 1);
    check_val("both_rej2", p2_rej, 1);
    idle(1);
    mv2(2'd0, 2'd2);
    check_val("bad2_rej", p2_rej, 1);
    check_val("bad2_red", cell_red, 0);
    go(); mv1(2'd0, 2'd3);
    check_val("bad1_rej", p1_rej, 1);
    check_val("bad1_blue", cell_blue, 0);

    // draw
    go();
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) mv1(2'(dr_r[i]), 2'(dr_c[i]));
      else            mv2(2'(dr_r[i]), 2'(dr_c[i]));
      idle(1);
    end
    check_val("draw_winner", winner, 3);
    check_val("draw_mc", move_count, 9);
    mv1(2'd2, 2'd2);
    check_val("draw_rej", p1_rej, 1);

    // timeout forfeit, then a move that coincides with the last counter value
    go(); idle(7);
    check_val("to_early", timeout, 0);
    idle(1);
    check_val("to_pulse", timeout, 1);
    check_val("to_turn", turn, 1);
    check_val("to_board", {cell_blue, cell_red}, 0);
    idle(7); mv2(2'd2, 2'd2);
    check_val("to_race_ack", p2_ack, 1);
    check_val("to_race_to", timeout, 0);
    idle(1);

    // start during CHECK with a same-cycle request
    mv1(2'd1, 2'd1);
    cycle(1, 0, 2'd0, 2'd0, 1, 2'd3, 2'd3);
    check_val("rs_chk_blue", cell_blue, 0);
    check_val("rs_chk_rej", p2_rej, 0);

    // async reset mid-game, then start with a request
    mv1(2'd1, 2'd1); idle(1);
    @(negedge clk); reset = 1; start = 0; p1_req = 0; p2_req = 0; #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk); reset = 0;
    cycle(0, 1, 2'd2, 2'd2, 0, 2'd0, 2'd0);
    cycle(1, 1, 2'd2, 2'd2, 0, 2'd0, 2'd0);
    check_val("rs_ack", p1_ack, 0);
    mv1(2'd1, 2'd1); idle(1);
    cycle(1, 1, 2'd2, 2'd2, 0, 2'd0, 2'd0);
    check_val("rs_wait_blue", cell_blue, 0);
    check_val("rs_wait_rej", p1_rej, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 40) == 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    check_val("sb_final", 16'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
